mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single data-memory/peripheral bus between two masters: M0 = CPU MEM stage
//  (MemRead/MemWrite/MemBus_Address/MemBus_Write_Data), M1 = DMA/UART engine. Round-robin
//  arbitration, one transfer in flight, variable-latency slave with ready, timeout error.
//  Drives m0_stall so the CPU freezes its pipeline while its access is pending.
// PARAMETERS
//  ADDR_W   32          bus address width
//  DATA_W   32          bus data width
//  TIMEOUT  16          max XFER cycles without bus_ready before error; 0 = wait forever
//  CNT_W    5           timeout counter width, must hold TIMEOUT
// PORTS
//  clk        in   1       single clock, rising edge
//  reset      in   1       asynchronous, active-high
//  m0_req     in   1       M0 request; held with m0_we/addr/wdata stable until m0_ack
//  m0_we      in   1       1 = write, 0 = read
//  m0_addr    in   ADDR_W  M0 address
//  m0_wdata   in   DATA_W  M0 write data
//  m0_ack     out  1       one-cycle completion pulse
//  m0_rdata   out  DATA_W  read data, valid while m0_ack
//  m0_err     out  1       timeout flag, valid while m0_ack
//  m0_stall   out  1       m0_req & ~m0_ack (combinational)
//  m1_*       -    -       same set as m0_* (req/we/addr/wdata/ack/rdata/err), no stall
//  bus_valid  out  1       transfer active toward slave
//  bus_we     out  1       latched write enable
//  bus_addr   out  ADDR_W  latched address
//  bus_wdata  out  DATA_W  latched write data
//  bus_ready  in   1       slave completes transfer this cycle
//  bus_rdata  in   DATA_W  slave read data, sampled when bus_valid & bus_ready
// BEHAVIOUR
//  Reset: state=IDLE, bus_valid/bus_we/ack/err=0, bus_addr/wdata/rdata outputs=0,
//   last_gnt=1 (M0 wins first tie), timeout counter=0. Reset mid-transfer aborts it; no ack.
//  FSM (registered outputs): IDLE -> XFER -> RESP -> IDLE.
//  IDLE: if any req: pick winner, latch we/addr/wdata and owner, clear counter -> XFER.
//   Only M0 or only M1 requesting -> that one. Both -> the one != last_gnt; last_gnt<=winner.
//  XFER: bus_valid=1, bus_* stable. bus_ready=1 -> capture bus_rdata, err=0 -> RESP.
//   Else counter++; counter==TIMEOUT-1 with no ready (TIMEOUT!=0) -> rdata=0, err=1 -> RESP.
//   Ready and timeout in same cycle: ready wins (err=0).
//  RESP: owner's ack=1 exactly one cycle with rdata/err; other master's ack=0; bus_valid=0.
//   Requester drops or changes req at the edge ending RESP; req seen in IDLE = new request.
//  Latency: req sampled edge k -> bus_valid from k+1 -> ready sampled edge k+n (n>=1)
//   -> ack high cycle after that edge. Minimum req-to-ack 2 cycles, 3 cycles occupancy.
//  Writes: rdata=0 on ack. Requests arriving during XFER/RESP wait; no preemption.
//  A master deasserting req before ack is a protocol violation; transfer still completes.
//  rdata/err of non-owner hold 0.
// STRUCTURE
//  Shared header bus_defs.vh: state localparams (S_IDLE=2'd0, S_XFER=2'd1, S_RESP=2'd2),
//   ERR_RDATA=32'h0, master index constants M0=1'b0, M1=1'b1.
//  One sub-module: rr_pick2 (combinational: req[1:0], last_gnt -> gnt_valid, gnt_idx).
//  Top holds FSM, latch registers, timeout counter, output muxing.
// TESTING
//  Single read: m0_req, addr=0x4000000C, slave ready 1st XFER cycle, rdata=0x12345678
//   -> m0_ack 2 cycles after req, m0_rdata=0x12345678, m0_err=0, m0_stall high until ack.
//  Tie: m0_req & m1_req same cycle, both held -> M0 served first, M1 next; repeat ties
//   alternate M1, M0; bus_addr matches owner each XFER.
//  Wait states: m1 write addr=0x40000010 wdata=0xA5A5A5A5, ready after 5 cycles -> bus_valid
//   high 5 cycles, bus_* constant, m1_ack 1 cycle, m1_rdata=0, m0_ack stays 0.
//  Timeout: TIMEOUT=16, ready never -> bus_valid 16 cycles, then m0_ack=1, m0_err=1,
//   m0_rdata=0; next request proceeds normally.
//  Ready on final timeout cycle -> err=0, rdata captured.
//  Reset asserted mid-XFER (async, between edges) -> bus_valid/acks 0 immediately,
//   state IDLE, held req re-served after release with M0 tie priority restored.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// rtl/mem_bus_arbiter_pkg.sv - shared state encoding and constants for the memory bus arbiter
package mem_bus_arbiter_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_XFER = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   // Read data returned alongside a timeout error.
   localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/mem_bus_arbiter_rr_pick2.sv
// rtl/mem_bus_arbiter_rr_pick2.sv - two-way round-robin pick; a tie goes to the master not granted last
module rr_pick2
   import mem_bus_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_gnt,
   output logic       gnt_valid,
   output logic       gnt_idx
);

   always_comb begin
      gnt_valid = |req;
      gnt_idx   = M0;
      if (req == 2'b11) begin
         gnt_idx = ~last_gnt;
      end else if (req[1]) begin
         gnt_idx = M1;
      end
   end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - shares one data bus between CPU (M0) and DMA (M1)
// Round-robin grant, one transfer in flight, slave wait states, timeout error.
module mem_bus_arbiter
   import mem_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic              clk,
   input  logic              reset,

   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_ack,
   output logic [DATA_W-1:0] m0_rdata,
   output logic              m0_err,
   output logic              m0_stall,

   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_ack,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              m1_err,

   output logic              bus_valid,
   output logic              bus_we,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ready,
   input  logic [DATA_W-1:0] bus_rdata
);

   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

   state_t              state_q, state_d;
   logic                last_gnt_q, last_gnt_d;
   logic                owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                gnt_valid;
   logic                gnt_idx;
   logic                timeout_hit;
   logic                resp_m0;
   logic                resp_m1;

   rr_pick2 u_pick (
      .req       ({m1_req, m0_req}),
      .last_gnt  (last_gnt_q),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   // TIMEOUT of 0 disables the limit: the transfer waits for ready forever.
   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         last_gnt_q <= M1;
         owner_q    <= M0;
         we_q       <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         rdata_q    <= '0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         last_gnt_q <= last_gnt_d;
         owner_q    <= owner_d;
         we_q       <= we_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      last_gnt_d = last_gnt_q;
      owner_d    = owner_q;
      we_d       = we_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (gnt_valid) begin
               owner_d = gnt_idx;
               // Only contested grants move the round-robin pointer.
               if (m0_req && m1_req) begin
                  last_gnt_d = gnt_idx;
               end
               we_d    = (gnt_idx == M1) ? m1_we    : m0_we;
               addr_d  = (gnt_idx == M1) ? m1_addr  : m0_addr;
               wdata_d = (gnt_idx == M1) ? m1_wdata : m0_wdata;
               cnt_d   = '0;
               state_d = S_XFER;
            end
         end
         S_XFER: begin
            if (bus_ready) begin
               rdata_d = we_q ? '0 : bus_rdata;
               err_d   = 1'b0;
               state_d = S_RESP;
            end else if (timeout_hit) begin
               rdata_d = DATA_W'(ERR_RDATA);
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_comb begin
      bus_valid = (state_q == S_XFER);
      bus_we    = we_q;
      bus_addr  = addr_q;
      bus_wdata = wdata_q;
      resp_m0   = (state_q == S_RESP) && (owner_q == M0);
      resp_m1   = (state_q == S_RESP) && (owner_q == M1);
      m0_ack    = resp_m0;
      m1_ack    = resp_m1;
      m0_rdata  = resp_m0 ? rdata_q : '0;
      m1_rdata  = resp_m1 ? rdata_q : '0;
      m0_err    = resp_m0 & err_q;
      m1_err    = resp_m1 & err_q;
      m0_stall  = m0_req & ~resp_m0;
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed and randomized bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

   localparam int TIMEOUT = 16;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  req_v = 2'b00;
   logic [1:0]  we_v = 2'b00;
   logic [31:0] addr_v [2];
   logic [31:0] wdata_v [2];
   logic        bus_ready = 1'b0;
   logic [31:0] bus_rdata = 32'h0;

   logic        m0_ack, m0_err, m0_stall, m1_ack, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic        bus_valid, bus_we;
   logic [31:0] bus_addr, bus_wdata;

   int n_cmp = 0;
   int n_bad = 0;

   mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT), .CNT_W(5)) dut (
      .clk       (clk),
      .reset     (reset),
      .m0_req    (req_v[0]),
      .m0_we     (we_v[0]),
      .m0_addr   (addr_v[0]),
      .m0_wdata  (wdata_v[0]),
      .m0_ack    (m0_ack),
      .m0_rdata  (m0_rdata),
      .m0_err    (m0_err),
      .m0_stall  (m0_stall),
      .m1_req    (req_v[1]),
      .m1_we     (we_v[1]),
      .m1_addr   (addr_v[1]),
      .m1_wdata  (wdata_v[1]),
      .m1_ack    (m1_ack),
      .m1_rdata  (m1_rdata),
      .m1_err    (m1_err),
      .bus_valid (bus_valid),
      .bus_we    (bus_we),
      .bus_addr  (bus_addr),
      .bus_wdata (bus_wdata),
      .bus_ready (bus_ready),
      .bus_rdata (bus_rdata)
   );

   always #5 clk = ~clk;

   // Transaction-level model: the transfer in flight, how long it has been on
   // the bus, and the response owed to its master.
   bit          mb_busy, mb_resp, mb_owner, mb_last, mb_we, mb_err;
   int          mb_cycles;
   logic [31:0] mb_addr, mb_wdata, mb_rd;
   int          ready_at = 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit w;
      if (reset) begin
         mb_busy = 0; mb_resp = 0; mb_owner = 0; mb_last = 1; mb_we = 0; mb_err = 0;
         mb_cycles = 0; mb_addr = 0; mb_wdata = 0; mb_rd = 0;
      end else if (mb_resp) begin
         mb_resp = 0;
      end else if (mb_busy) begin
         mb_cycles++;
         if (bus_ready) begin
            mb_rd = mb_we ? 32'h0 : bus_rdata;
            mb_err = 0; mb_busy = 0; mb_resp = 1;
         end else if (TIMEOUT != 0 && mb_cycles == TIMEOUT) begin
            mb_rd = 32'h0; mb_err = 1; mb_busy = 0; mb_resp = 1;
         end
      end else if (req_v != 2'b00) begin
         if (req_v == 2'b11) begin
            w = ~mb_last;
            mb_last = w;
         end else begin
            w = req_v[1];
         end
         mb_owner = w; mb_we = we_v[w]; mb_addr = addr_v[w]; mb_wdata = wdata_v[w];
         mb_busy = 1; mb_cycles = 0;
      end
   endtask

   // Model advances on each edge; outputs are checked 2 ns later.
   always begin
      bit a0, a1;
      @(posedge clk);
      model_edge();
      #2;
      a0 = mb_resp && (mb_owner == 1'b0);
      a1 = mb_resp && (mb_owner == 1'b1);
      chk("bus_valid", bus_valid, mb_busy);
      chk("bus_we", bus_we, mb_we);
      chk("bus_addr", bus_addr, mb_addr);
      chk("bus_wdata", bus_wdata, mb_wdata);
      chk("m0_ack", m0_ack, a0);
      chk("m1_ack", m1_ack, a1);
      chk("m0_rdata", m0_rdata, a0 ? mb_rd : 32'h0);
      chk("m1_rdata", m1_rdata, a1 ? mb_rd : 32'h0);
      chk("m0_err", m0_err, a0 & mb_err);
      chk("m1_err", m1_err, a1 & mb_err);
      chk("m0_stall", m0_stall, req_v[0] & ~a0);
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic new_txn(input int i);
      req_v[i]   = 1'b1;
      we_v[i]    = 1'($urandom_range(0, 1));
      addr_v[i]  = {16'h4000, 16'($urandom)};
      wdata_v[i] = $urandom;
   endtask

   initial begin
      addr_v[0] = 0; addr_v[1] = 0; wdata_v[0] = 0; wdata_v[1] = 0;
      repeat (3) cyc();
      chk("rst_bus_valid", bus_valid, 0);
      chk("rst_bus_addr", bus_addr, 0);
      chk("rst_m0_ack", m0_ack, 0);
      chk("rst_m1_ack", m1_ack, 0);
      reset = 1'b0;
      cyc();

      // Single read, slave ready on the first bus cycle.
      req_v[0] = 1; we_v[0] = 0; addr_v[0] = 32'h4000000C;
      bus_ready = 1; bus_rdata = 32'h12345678;
      cyc();
      chk("rd_valid", bus_valid, 1);
      chk("rd_addr", bus_addr, 32'h4000000C);
      chk("rd_stall", m0_stall, 1);
      chk("rd_early_ack", m0_ack, 0);
      cyc();
      chk("rd_ack", m0_ack, 1);
      chk("rd_rdata", m0_rdata, 32'h12345678);
      chk("rd_err", m0_err, 0);
      chk("rd_stall_off", m0_stall, 0);
      req_v[0] = 0; bus_ready = 0;
      cyc();

      // Tie held by both masters: grants alternate M0, M1, M0, M1.
      req_v = 2'b11; we_v = 2'b00; addr_v[0] = 32'h40000100; addr_v[1] = 32'h40000200;
      bus_ready = 1;
      for (int t = 0; t < 4; t++) begin
         cyc();
         chk("tie_addr", bus_addr, (t % 2 == 0) ? 32'h40000100 : 32'h40000200);
         cyc();
         chk("tie_ack_m0", m0_ack, (t % 2 == 0) ? 1 : 0);
         chk("tie_ack_m1", m1_ack, (t % 2 == 1) ? 1 : 0);
         cyc();
      end
      req_v = 2'b00; bus_ready = 0;
      cyc();

      // M1 write with five bus cycles before ready.
      req_v[1] = 1; we_v[1] = 1; addr_v[1] = 32'h40000010; wdata_v[1] = 32'hA5A5A5A5;
      bus_rdata = 32'hDEADBEEF;
      cyc();
      for (int c = 1; c <= 5; c++) begin
         chk("ws_valid", bus_valid, 1);
         chk("ws_addr", bus_addr, 32'h40000010);
         chk("ws_wdata", bus_wdata, 32'hA5A5A5A5);
         chk("ws_we", bus_we, 1);
         bus_ready = (c == 5);
         cyc();
      end
      chk("ws_ack", m1_ack, 1);
      chk("ws_rdata", m1_rdata, 0);
      chk("ws_m0_ack", m0_ack, 0);
      req_v[1] = 0; bus_ready = 0;
      cyc();

      // Timeout: ready never arrives.
      req_v[0] = 1; we_v[0] = 0; addr_v[0] = 32'h40000020; bus_rdata = 32'hFFFFFFFF;
      cyc();
      for (int c = 1; c <= TIMEOUT; c++) begin
         chk("to_valid", bus_valid, 1);
         cyc();
      end
      chk("to_ack", m0_ack, 1);
      chk("to_err", m0_err, 1);
      chk("to_rdata", m0_rdata, 0);
      req_v[0] = 0;
      cyc();

      // Ready on the last cycle before the timeout would fire.
      req_v[0] = 1; addr_v[0] = 32'h40000024; bus_rdata = 32'hCAFEF00D;
      cyc();
      for (int c = 1; c <= TIMEOUT; c++) begin
         bus_ready = (c == TIMEOUT);
         cyc();
      end
      chk("last_ack", m0_ack, 1);
      chk("last_err", m0_err, 0);
      chk("last_rdata", m0_rdata, 32'hCAFEF00D);
      req_v[0] = 0; bus_ready = 0;
      cyc();

      // Asynchronous reset during M0's transfer, taken when M1 would win the next tie.
      req_v = 2'b11; addr_v[0] = 32'h40000030; addr_v[1] = 32'h40000034;
      cyc();
      chk("rr_addr_pre", bus_addr, 32'h40000030);
      cyc();
      #3 reset = 1'b1;
      #1;
      chk("rr_valid", bus_valid, 0);
      chk("rr_ack0", m0_ack, 0);
      chk("rr_ack1", m1_ack, 0);
      cyc();
      reset = 1'b0;
      cyc();
      chk("rr_addr_post", bus_addr, 32'h40000030);
      bus_ready = 1;
      cyc();
      chk("rr_ack_post", m0_ack, 1);
      req_v = 2'b00; bus_ready = 0;
      cyc();
      cyc();

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (mb_resp && (mb_owner == 1'(i))) begin
               if ($urandom_range(0, 1) == 1) new_txn(i);
               else req_v[i] = 1'b0;
            end else if (!req_v[i] && $urandom_range(0, 3) == 0) begin
               new_txn(i);
            end
         end
         if (mb_busy && mb_cycles == 0) begin
            case ($urandom_range(0, 9))
               0:       ready_at = TIMEOUT;
               1, 2:    ready_at = 1000;
               default: ready_at = int'($urandom_range(1, 4));
            endcase
         end
         bus_ready = mb_busy ? (mb_cycles + 1 == ready_at) : 1'($urandom_range(0, 1));
         bus_rdata = $urandom;
         cyc();
      end

      // Drain: masters only retire outstanding requests.
      for (int n = 0; n < 60; n++) begin
         for (int i = 0; i < 2; i++) begin
            if (mb_resp && (mb_owner == 1'(i))) req_v[i] = 1'b0;
         end
         bus_ready = mb_busy;
         cyc();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
